// File: rtl/clock_period_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : clock_period_monitor                                         |
// | Description : Measures the period of an asynchronous monitored clock in    |
// |               CLK_IN cycles, flags out-of-tolerance periods and a stopped  |
// |               clock, and declares lock after consecutive good periods.     |
// | Options     : define CLKMON_DUTY_EN to add the HIGH_TIME measurement.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clock_period_monitor #(
  parameter int CNT_W      = 32,
  parameter int EXP_PERIOD = 50000000,
  parameter int TOL        = 50000,
  parameter int TIMEOUT    = 100000000,
  parameter int LOCK_CNT   = 4
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic             MON_CLK,
  input  logic             CLR_ERR,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             IN_RANGE,
  output logic             RANGE_ERR,
  output logic             TIMEOUT_ERR,
  output logic             LOCKED
`ifdef CLKMON_DUTY_EN
  ,
  output logic [CNT_W-1:0] HIGH_TIME
`endif
);

  localparam int LCW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  // Tolerance window, evaluated once at elaboration; low bound clamps at zero.
  localparam logic [63:0]    c_hi_bound  = 64'(EXP_PERIOD) + 64'(TOL);
  localparam logic [63:0]    c_lo_bound  = (EXP_PERIOD > TOL) ? 64'(EXP_PERIOD - TOL) : 64'd0;
  localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   c_timeout_x = (CNT_W + 1)'(TIMEOUT);
  localparam logic [LCW-1:0]   c_lock_max  = LCW'(LOCK_CNT);

  typedef enum logic [0:0] {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  logic             sync1_q, sync2_q, sync3_q;
  logic             rise;
  logic [CNT_W:0]   cnt_inc;
  logic             in_window;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             in_range_q, in_range_d;
  logic             range_err_q, range_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic             locked_q, locked_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;

  assign rise      = sync2_q & ~sync3_q;
  // One wider than the counter so cnt+1 is exact for the window and timeout tests.
  assign cnt_inc   = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign in_window = (64'(cnt_inc) >= c_lo_bound) && (64'(cnt_inc) <= c_hi_bound);

  // Synchronizer, edge-detect flop and all monitor state registers.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      state_q       <= SEEK;
      cnt_q         <= '0;
      period_q      <= '0;
      pv_q          <= 1'b0;
      in_range_q    <= 1'b0;
      range_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      locked_q      <= 1'b0;
      lock_cnt_q    <= '0;
    end else begin
      sync1_q       <= MON_CLK;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      pv_q          <= pv_d;
      in_range_q    <= in_range_d;
      range_err_q   <= range_err_d;
      timeout_err_q <= timeout_err_d;
      locked_q      <= locked_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

  // Next-state logic: period capture, range judgement, lock tracking, timeout.
  always_comb begin
    state_d       = state_q;
    cnt_d         = rise ? '0 : ((cnt_q == c_timeout) ? cnt_q : cnt_inc[CNT_W-1:0]);
    period_d      = period_q;
    pv_d          = 1'b0;
    in_range_d    = in_range_q;
    // Clearing first lets a same-cycle new error override the clear below.
    range_err_d   = range_err_q & ~CLR_ERR;
    timeout_err_d = timeout_err_q & ~CLR_ERR;
    locked_d      = locked_q;
    lock_cnt_d    = lock_cnt_q;
    case (state_q)
      SEEK: begin
        // First edge only opens a measurement window.
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          // A rise coinciding with the timeout threshold is a normal period.
          period_d   = cnt_inc[CNT_W-1:0];
          pv_d       = 1'b1;
          in_range_d = in_window;
          if (in_window) begin
            if (lock_cnt_q != c_lock_max) lock_cnt_d = lock_cnt_q + LCW'(1);
            locked_d = (lock_cnt_d == c_lock_max);
          end else begin
            lock_cnt_d  = '0;
            locked_d    = 1'b0;
            range_err_d = 1'b1;
          end
        end else if (cnt_inc == c_timeout_x) begin
          timeout_err_d = 1'b1;
          in_range_d    = 1'b0;
          locked_d      = 1'b0;
          lock_cnt_d    = '0;
          state_d       = SEEK;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  assign PERIOD       = period_q;
  assign PERIOD_VALID = pv_q;
  assign IN_RANGE     = in_range_q;
  assign RANGE_ERR    = range_err_q;
  assign TIMEOUT_ERR  = timeout_err_q;
  assign LOCKED       = locked_q;

`ifdef CLKMON_DUTY_EN
  logic             fall;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;

  assign fall = ~sync2_q & sync3_q;

  // High-time counter, fall capture and publication with the next period.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      high_cnt_q  <= '0;
      high_cap_q  <= '0;
      high_time_q <= '0;
    end else begin
      high_cnt_q  <= high_cnt_d;
      high_cap_q  <= high_cap_d;
      high_time_q <= high_time_d;
    end
  end

  // A missing fall leaves the capture untouched, so the old value is republished.
  always_comb begin
    high_cnt_d  = rise ? '0 : ((high_cnt_q == c_timeout) ? high_cnt_q : high_cnt_q + CNT_W'(1));
    high_cap_d  = fall ? high_cnt_q + CNT_W'(1) : high_cap_q;
    high_time_d = pv_d ? high_cap_q : high_time_q;
  end

  assign HIGH_TIME = high_time_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_period_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_clock_period_monitor                                      |
// | Description : Directed table-driven bench for clock_period_monitor with    |
// |               a MON_CLK generated synchronously from CLK_IN.               |
// |               HIGH_TIME is checked when CLKMON_DUTY_EN is defined.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_clock_period_monitor;

  localparam int CNT_W      = 8;
  localparam int EXP_PERIOD = 10;
  localparam int TOL        = 1;
  localparam int TIMEOUT    = 32;
  localparam int LOCK_CNT   = 3;

  logic             CLK_IN = 1'b0;
  logic             RST;
  logic             MON_CLK;
  logic             CLR_ERR;
  logic [CNT_W-1:0] PERIOD;
  logic             PERIOD_VALID;
  logic             IN_RANGE;
  logic             RANGE_ERR;
  logic             TIMEOUT_ERR;
  logic             LOCKED;
`ifdef CLKMON_DUTY_EN
  logic [CNT_W-1:0] HIGH_TIME;
`endif

  clock_period_monitor #(
    .CNT_W     (CNT_W),
    .EXP_PERIOD(EXP_PERIOD),
    .TOL       (TOL),
    .TIMEOUT   (TIMEOUT),
    .LOCK_CNT  (LOCK_CNT)
  ) u_dut (
    .CLK_IN      (CLK_IN),
    .RST         (RST),
    .MON_CLK     (MON_CLK),
    .CLR_ERR     (CLR_ERR),
    .PERIOD      (PERIOD),
    .PERIOD_VALID(PERIOD_VALID),
    .IN_RANGE    (IN_RANGE),
    .RANGE_ERR   (RANGE_ERR),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .LOCKED      (LOCKED)
`ifdef CLKMON_DUTY_EN
    ,
    .HIGH_TIME   (HIGH_TIME)
`endif
  );

  always #5 CLK_IN = ~CLK_IN;

  // One MON_CLK period starting with its rise, plus the PERIOD_VALID that the
  // rise produces (which reports the previous record's period).
  typedef struct {
    int high;
    int low;
    int clr_k;
    bit pv;
    int period;
    bit ir;
    bit rerr;
    bit terr;
    bit lock;
  } vec_t;

  vec_t tab[$];
  int   n_checks  = 0;
  int   n_err     = 0;
  int   prev_high = 0;

  function automatic vec_t mk(int h, int l, int c, bit pv, int per, bit ir, bit rerr, bit terr, bit lock);
    vec_t v;
    v.high = h; v.low = l; v.clr_k = c; v.pv = pv; v.period = per;
    v.ir = ir; v.rerr = rerr; v.terr = terr; v.lock = lock;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " PERIOD"},       32'(PERIOD),       32'd0);
    chk({tag, " PERIOD_VALID"}, 32'(PERIOD_VALID), 32'd0);
    chk({tag, " IN_RANGE"},     32'(IN_RANGE),     32'd0);
    chk({tag, " RANGE_ERR"},    32'(RANGE_ERR),    32'd0);
    chk({tag, " TIMEOUT_ERR"},  32'(TIMEOUT_ERR),  32'd0);
    chk({tag, " LOCKED"},       32'(LOCKED),       32'd0);
`ifdef CLKMON_DUTY_EN
    chk({tag, " HIGH_TIME"},    32'(HIGH_TIME),    32'd0);
`endif
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   npv;
    v   = tab[idx];
    npv = 0;
    MON_CLK = 1'b1;
    for (int k = 0; k < v.high + v.low; k++) begin
      if (k == v.high) MON_CLK = 1'b0;
      CLR_ERR = (k == v.clr_k);
      tick();
      if (PERIOD_VALID) begin
        npv++;
        if (v.pv) begin
          chk($sformatf("v%0d PERIOD", idx),      32'(PERIOD),      32'(v.period));
          chk($sformatf("v%0d IN_RANGE", idx),    32'(IN_RANGE),    32'(v.ir));
          chk($sformatf("v%0d RANGE_ERR", idx),   32'(RANGE_ERR),   32'(v.rerr));
          chk($sformatf("v%0d TIMEOUT_ERR", idx), 32'(TIMEOUT_ERR), 32'(v.terr));
          chk($sformatf("v%0d LOCKED", idx),      32'(LOCKED),      32'(v.lock));
`ifdef CLKMON_DUTY_EN
          chk($sformatf("v%0d HIGH_TIME", idx),   32'(HIGH_TIME),   32'(prev_high));
`endif
        end
      end
    end
    CLR_ERR = 1'b0;
    chk($sformatf("v%0d pv_count", idx), 32'(npv), v.pv ? 32'd1 : 32'd0);
    prev_high = v.high;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Lock and tolerance edges (idx 0-9)
    //                  h  l  clr pv per ir rerr terr lock
    tab.push_back(mk(5, 5, -1, 0,  0, 0, 0, 0, 0));
    tab.push_back(mk(5, 5, -1, 1, 10, 1, 0, 0, 0));
    tab.push_back(mk(5, 5, -1, 1, 10, 1, 0, 0, 0));
    tab.push_back(mk(5, 4, -1, 1, 10, 1, 0, 0, 1));
    tab.push_back(mk(5, 6, -1, 1,  9, 1, 0, 0, 1));
    tab.push_back(mk(6, 6, -1, 1, 11, 1, 0, 0, 1));
    tab.push_back(mk(5, 5,  2, 1, 12, 0, 1, 0, 0));  // clear collides with range error
    tab.push_back(mk(5, 5, -1, 1, 10, 1, 1, 0, 0));
    tab.push_back(mk(5, 5, -1, 1, 10, 1, 1, 0, 0));
    tab.push_back(mk(5, 5, -1, 1, 10, 1, 1, 0, 1));
    // Restart after timeout; period equal to TIMEOUT (idx 10-13)
    tab.push_back(mk(5, 5, -1, 0,  0, 0, 0, 0, 0));
    tab.push_back(mk(5, 27, -1, 1, 10, 1, 0, 0, 0));
    tab.push_back(mk(5, 5, -1, 1, 32, 0, 1, 0, 0));
    tab.push_back(mk(5, 5, -1, 1, 10, 1, 1, 0, 0));
    // Leaves the counter at 6 for the mid-period reset (idx 14)
    tab.push_back(mk(5, 4, -1, 1, 10, 1, 1, 0, 0));
    // After reset, then 3-high/7-low duty pattern (idx 15-19)
    tab.push_back(mk(5, 5, -1, 0,  0, 0, 0, 0, 0));
    tab.push_back(mk(5, 5, -1, 1, 10, 1, 0, 0, 0));
    tab.push_back(mk(3, 7, -1, 1, 10, 1, 0, 0, 0));
    tab.push_back(mk(3, 7, -1, 1, 10, 1, 0, 0, 1));
    tab.push_back(mk(3, 7, -1, 1, 10, 1, 0, 0, 1));

    RST     = 1'b1;
    MON_CLK = 1'b0;
    CLR_ERR = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    RST = 1'b0;
    tick();

    for (int i = 0; i <= 9; i++) run_vec(i);

    // Last PERIOD_VALID was 7 samples ago; the timeout lands 32 after it.
    repeat (24) tick();
    chk("timeout early TIMEOUT_ERR", 32'(TIMEOUT_ERR), 32'd0);
    chk("timeout early LOCKED",      32'(LOCKED),      32'd1);
    tick();
    chk("timeout TIMEOUT_ERR", 32'(TIMEOUT_ERR), 32'd1);
    chk("timeout LOCKED",      32'(LOCKED),      32'd0);
    chk("timeout IN_RANGE",    32'(IN_RANGE),    32'd0);
    chk("timeout RANGE_ERR",   32'(RANGE_ERR),   32'd1);

    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("clear RANGE_ERR",   32'(RANGE_ERR),   32'd0);
    chk("clear TIMEOUT_ERR", 32'(TIMEOUT_ERR), 32'd0);
    chk("clear PERIOD",      32'(PERIOD),      32'd10);

    for (int i = 10; i <= 14; i++) run_vec(i);

    RST = 1'b1;
    tick();
    chk_reset_outputs("midreset");
    RST = 1'b0;

    for (int i = 15; i <= 19; i++) run_vec(i);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_period_monitor.md
# clock_period_monitor

- Receive-side checker for the divided clock produced by the clock generator (e.g. the 1 Hz output).
- Synchronizes the monitored clock into the CLK_IN domain and measures each period in CLK_IN cycles.
- Flags out-of-tolerance periods and a stopped clock.
- Declares lock after consecutive good periods; firmware and bring-up logic use it to confirm the generator is running at the right rate.

## Interface

Parameters:
- CNT_W, 32, width of period counter and PERIOD output.
- EXP_PERIOD, 50000000, expected period in CLK_IN cycles (1 Hz at 50 MHz).
- TOL, 50000, allowed deviation; in range when EXP_PERIOD-TOL <= PERIOD <= EXP_PERIOD+TOL.
- TIMEOUT, 100000000, cycles without a detected edge before declaring the clock dead; must be > EXP_PERIOD+TOL and < 2^CNT_W.
- LOCK_CNT, 4, consecutive in-range periods required for LOCKED.

Ports:
- CLK_IN, input, 1, system clock; all logic on its rising edge.
- RST, input, 1, synchronous active-high reset.
- MON_CLK, input, 1, monitored clock; asynchronous to CLK_IN.
- CLR_ERR, input, 1, single-cycle pulse; clears sticky error flags.
- PERIOD, output, CNT_W, last measured period in CLK_IN cycles.
- PERIOD_VALID, output, 1, one-cycle pulse when PERIOD updates.
- IN_RANGE, output, 1, last measured period was within tolerance.
- RANGE_ERR, output, 1, sticky; set by any out-of-range period.
- TIMEOUT_ERR, output, 1, sticky; set on timeout.
- LOCKED, output, 1, LOCK_CNT consecutive in-range periods seen, with no error since.
- HIGH_TIME, output, CNT_W, only present with CLKMON_DUTY_EN; last measured high time.

## Operation

- Input path:
  - MON_CLK passes through a 2-flop synchronizer, then a third flop for edge detection.
  - rise = sync2 & ~sync3; fall = ~sync2 & sync3.
- Counter cnt:
  - Cleared to 0 on rise; otherwise increments.
  - Saturates at TIMEOUT and never wraps.
- FSM states: SEEK, MEASURE.
  - Reset: enter SEEK with cnt=0.
  - SEEK: on first rise, clear cnt and go to MEASURE. No PERIOD update, since the first edge only starts a measurement.
  - MEASURE, on rise:
    - PERIOD <= cnt+1.
    - Pulse PERIOD_VALID.
    - Evaluate the range and update IN_RANGE.
    - Clear cnt; stay in MEASURE.
  - MEASURE, when cnt+1 == TIMEOUT and no rise that cycle:
    - Set TIMEOUT_ERR.
    - Clear IN_RANGE, LOCKED and the lock counter.
    - Go to SEEK.
- Range check:
  - Unsigned compare of the new period against EXP_PERIOD±TOL.
  - Bounds are computed at elaboration; the lower bound clamps at 0.
- Lock counter:
  - Increments on each in-range period and saturates at LOCK_CNT.
  - An out-of-range period clears it and LOCKED, and sets RANGE_ERR.
  - LOCKED = 1 when the counter reaches LOCK_CNT.
- CLR_ERR: clears RANGE_ERR and TIMEOUT_ERR. It does not affect LOCKED, PERIOD or the FSM.
- Simultaneous events:
  - CLR_ERR together with a new error: the error wins and the flag stays set.
  - rise on the same cycle the timeout would fire: the rise wins. The period is recorded as TIMEOUT and judged by range, with no timeout.
- RST takes priority over everything.

## Timing

- Reset values: PERIOD=0, PERIOD_VALID=0, IN_RANGE=0, RANGE_ERR=0, TIMEOUT_ERR=0, LOCKED=0, HIGH_TIME=0, state SEEK, lock counter 0.
- Latency:
  - MON_CLK rising to rise detection: 2–3 CLK_IN cycles (synchronizer).
  - PERIOD, PERIOD_VALID and IN_RANGE are registered and valid the cycle after rise detection.
  - LOCKED, RANGE_ERR and TIMEOUT_ERR update in that same cycle.
- Measured period jitters by ±1 cycle for asynchronous input. An exact integer-ratio stimulus gives an exact count.
- Minimum measurable MON_CLK high/low time: 2 CLK_IN cycles. Shorter pulses may be missed; no error is flagged for them.
- PERIOD_VALID never asserts on two consecutive cycles.

## Configuration

- Macro: CLKMON_DUTY_EN.
- Defined:
  - A second counter clears on rise and captures cnt+1 into HIGH_TIME on fall.
  - HIGH_TIME is published alongside the next PERIOD_VALID.
  - A missing fall between rises holds the previous HIGH_TIME.
- Undefined: the HIGH_TIME port and its counter are absent; all other behaviour is identical.

## Test plan

Bench parameters: EXP_PERIOD=10, TOL=1, TIMEOUT=32, LOCK_CNT=3, CNT_W=8. MON_CLK is generated synchronously from CLK_IN.

- **Lock:** hold RST for 3 cycles, then MON_CLK period 10 (5 high/5 low) -> first PERIOD_VALID on the 2nd rise with PERIOD=10, IN_RANGE=1; LOCKED=1 on the 4th rise; no error flags.
- **Tolerance edges:** periods 9, 11 -> IN_RANGE=1. Then period 12 -> IN_RANGE=0, RANGE_ERR=1, LOCKED=0. Three more periods of 10 -> LOCKED=1, RANGE_ERR still 1.
- **Timeout:** stop MON_CLK low after lock -> TIMEOUT_ERR=1 exactly 32 cycles after the last detected rise; LOCKED=0, IN_RANGE=0, state SEEK. Restarting the clock gives no PERIOD_VALID on the first rise.
- **Clear:** CLR_ERR pulse -> both sticky flags drop next cycle. CLR_ERR on the same cycle as an out-of-range PERIOD_VALID -> RANGE_ERR stays 1.
- **Reset mid-period:** assert RST while cnt=6 -> all outputs return to reset values next cycle; after release, the first rise produces no PERIOD_VALID.
- **Duty (CLKMON_DUTY_EN):** MON_CLK 3 high/7 low -> HIGH_TIME=3, PERIOD=10 on the same PERIOD_VALID.
